// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_pkg
// Brief    : Opcode/function constants, FSM encodings and helpers for EX.
// Revision : 1.0
// ============================================================================
package execute_stage_pkg;

    localparam logic [3:0] C_OP_RTYPE = 4'hF;
    localparam logic [3:0] C_OP_ANDI  = 4'h1;
    localparam logic [3:0] C_OP_ORI   = 4'h2;
    localparam logic [3:0] C_OP_LW    = 4'h8;
    localparam logic [3:0] C_OP_SW    = 4'hB;

    localparam logic [3:0] C_FN_ADD = 4'h0;
    localparam logic [3:0] C_FN_SUB = 4'h1;
    localparam logic [3:0] C_FN_AND = 4'h4;
    localparam logic [3:0] C_FN_OR  = 4'h5;
    localparam logic [3:0] C_FN_MUL = 4'h8;
    localparam logic [3:0] C_FN_DIV = 4'h9;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef struct packed {
        logic reg_write;
        logic r0_write;
        logic mem_read;
        logic mem_write;
        logic mem_source;
    } ctrl_t;

    // MEM stage has priority over WB; register 0 is not special.
    function automatic logic [15:0] fwd_operand(
        input logic [3:0]  ra,
        input logic [15:0] rd,
        input logic        mem_we,
        input logic [3:0]  mem_reg,
        input logic [15:0] mem_data,
        input logic        wb_we,
        input logic [3:0]  wb_reg,
        input logic [15:0] wb_data
    );
        if (mem_we && (mem_reg == ra))
            return mem_data;
        else if (wb_we && (wb_reg == ra))
            return wb_data;
        else
            return rd;
    endfunction

    function automatic logic add_sub_ovf(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] r,
        input logic        sub
    );
        if (sub)
            return (a[15] != b[15]) && (r[15] != a[15]);
        else
            return (a[15] == b[15]) && (r[15] != a[15]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Brief    : ID/EX fields, MEM/WB forwarding taps and EX/MEM register bundle.
// Revision : 1.0
// ============================================================================
interface execute_stage_if;
    logic        flush;
    logic [3:0]  opcode_EX;
    logic [3:0]  FN_offset_EX;
    logic [3:0]  RA1_EX;
    logic [3:0]  RA2_EX;
    logic [15:0] RD1_EX;
    logic [15:0] RD2_EX;
    logic [15:0] SE_offset_EX;
    logic        regWrite_EX;
    logic        r0Write_EX;
    logic        alusource_EX;
    logic        memRead_EX;
    logic        memWrite_EX;
    logic        memSource_EX;
    logic        fwd_mem_we;
    logic        fwd_wb_we;
    logic [3:0]  fwd_mem_reg;
    logic [3:0]  fwd_wb_reg;
    logic [15:0] fwd_mem_data;
    logic [15:0] fwd_wb_data;
    logic [15:0] alu_result_MEM;
    logic [15:0] r0_result_MEM;
    logic [15:0] store_data_MEM;
    logic [3:0]  dest_MEM;
    logic        regWrite_MEM;
    logic        r0Write_MEM;
    logic        memRead_MEM;
    logic        memWrite_MEM;
    logic        memSource_MEM;
    logic        ovf_MEM;
    logic        stall_EX;

    modport slave (
        input  flush, opcode_EX, FN_offset_EX, RA1_EX, RA2_EX, RD1_EX, RD2_EX,
               SE_offset_EX, regWrite_EX, r0Write_EX, alusource_EX, memRead_EX,
               memWrite_EX, memSource_EX, fwd_mem_we, fwd_wb_we, fwd_mem_reg,
               fwd_wb_reg, fwd_mem_data, fwd_wb_data,
        output alu_result_MEM, r0_result_MEM, store_data_MEM, dest_MEM,
               regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM,
               memSource_MEM, ovf_MEM, stall_EX
    );

    modport master (
        output flush, opcode_EX, FN_offset_EX, RA1_EX, RA2_EX, RD1_EX, RD2_EX,
               SE_offset_EX, regWrite_EX, r0Write_EX, alusource_EX, memRead_EX,
               memWrite_EX, memSource_EX, fwd_mem_we, fwd_wb_we, fwd_mem_reg,
               fwd_wb_reg, fwd_mem_data, fwd_wb_data,
        input  alu_result_MEM, r0_result_MEM, store_data_MEM, dest_MEM,
               regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM,
               memSource_MEM, ovf_MEM, stall_EX
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative 16-step signed multiply / restoring divide on magnitudes.
// Revision : 1.0
// ============================================================================
module ex_muldiv
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_div,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        stall,
    output logic        done,
    output logic [15:0] res_lo,
    output logic [15:0] res_hi
);
    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_count;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [15:0] r_mag;
    logic        r_sa;
    logic        r_sb;
    logic        r_div;
    logic        r_dz;

    logic        w_div_zero;
    logic [15:0] w_mag_a;
    logic [15:0] w_mag_b;
    logic [16:0] w_sum;
    logic [16:0] w_shift;
    logic        w_ge;
    logic [15:0] w_diff;
    logic [31:0] w_prod;
    logic [31:0] w_prod_s;

    assign w_div_zero = is_div && (b == 16'h0000);
    assign w_mag_a    = a[15] ? (16'h0000 - a) : a;
    assign w_mag_b    = b[15] ? (16'h0000 - b) : b;
    assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : 17'h00000);
    assign w_shift    = {r_hi, r_lo[15]};
    assign w_ge       = w_shift >= {1'b0, r_mag};
    // Remainder stays below the divisor, so the 16-bit wrap is exact when w_ge.
    assign w_diff     = w_shift[15:0] - r_mag;
    assign w_prod     = {r_hi, r_lo};
    assign w_prod_s   = (r_sa ^ r_sb) ? (32'h0000_0000 - w_prod) : w_prod;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= C_ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_ST_IDLE: if (start) w_next = w_div_zero ? C_ST_DONE : C_ST_BUSY;
            C_ST_BUSY: if (r_count == 4'd15) w_next = C_ST_DONE;
            C_ST_DONE: w_next = C_ST_IDLE;
            default:   w_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        stall  = ((r_state == C_ST_IDLE) && start) || (r_state == C_ST_BUSY);
        done   = (r_state == C_ST_DONE);
        res_lo = w_prod_s[15:0];
        res_hi = w_prod_s[31:16];
        if (r_div) begin
            res_lo = r_dz ? r_lo : ((r_sa ^ r_sb) ? (16'h0000 - r_lo) : r_lo);
            res_hi = r_sa ? (16'h0000 - r_hi) : r_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
            r_hi    <= 16'h0000;
            r_lo    <= 16'h0000;
            r_mag   <= 16'h0000;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
        end else if ((r_state == C_ST_IDLE) && start) begin
            r_count <= 4'd0;
            r_sa    <= a[15];
            r_sb    <= b[15];
            r_div   <= is_div;
            r_dz    <= w_div_zero;
            if (is_div) begin
                r_hi  <= w_div_zero ? w_mag_a : 16'h0000;
                r_lo  <= w_div_zero ? 16'hFFFF : w_mag_a;
                r_mag <= w_mag_b;
            end else begin
                r_hi  <= 16'h0000;
                r_lo  <= w_mag_b;
                r_mag <= w_mag_a;
            end
        end else if (r_state == C_ST_BUSY) begin
            r_count <= r_count + 4'd1;
            if (r_div) begin
                r_hi <= w_ge ? w_diff : w_shift[15:0];
                r_lo <= {r_lo[14:0], w_ge};
            end else begin
                r_hi <= w_sum[16:1];
                r_lo <= {w_sum[0], r_lo[15:1]};
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : EX stage: operand forwarding, ALU, mul/div unit, EX/MEM register.
// Revision : 1.0
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    execute_stage_if.slave  ex
);
    logic [15:0] w_a;
    logic [15:0] w_b_reg;
    logic [15:0] w_b;
    logic [15:0] w_alu;
    logic        w_ovf;
    logic        w_bad_fn;
    logic        w_is_md;
    logic        w_start;
    logic        w_stall;
    logic        w_md_done;
    logic [15:0] w_md_lo;
    logic [15:0] w_md_hi;
    logic        w_bubble;
    ctrl_t       w_ctrl;

    logic [15:0] r_alu;
    logic [15:0] r_r0;
    logic [15:0] r_store;
    logic [3:0]  r_dest;
    ctrl_t       r_ctrl;
    logic        r_ovf;

    assign w_a = fwd_operand(ex.RA1_EX, ex.RD1_EX, ex.fwd_mem_we, ex.fwd_mem_reg,
                             ex.fwd_mem_data, ex.fwd_wb_we, ex.fwd_wb_reg, ex.fwd_wb_data);
    assign w_b_reg = fwd_operand(ex.RA2_EX, ex.RD2_EX, ex.fwd_mem_we, ex.fwd_mem_reg,
                                 ex.fwd_mem_data, ex.fwd_wb_we, ex.fwd_wb_reg, ex.fwd_wb_data);
    assign w_b = ex.alusource_EX ? ex.SE_offset_EX : w_b_reg;

    assign w_is_md = (ex.opcode_EX == C_OP_RTYPE) &&
                     ((ex.FN_offset_EX == C_FN_MUL) || (ex.FN_offset_EX == C_FN_DIV));
    assign w_start = w_is_md && !ex.flush;
    assign w_ctrl  = '{ex.regWrite_EX, ex.r0Write_EX, ex.memRead_EX,
                       ex.memWrite_EX, ex.memSource_EX};

    always_comb begin
        w_alu    = w_a + w_b;
        w_ovf    = 1'b0;
        w_bad_fn = 1'b0;
        case (ex.opcode_EX)
            C_OP_RTYPE: begin
                case (ex.FN_offset_EX)
                    C_FN_ADD: begin
                        w_alu = w_a + w_b;
                        w_ovf = add_sub_ovf(w_a, w_b, w_alu, 1'b0);
                    end
                    C_FN_SUB: begin
                        w_alu = w_a - w_b;
                        w_ovf = add_sub_ovf(w_a, w_b, w_alu, 1'b1);
                    end
                    C_FN_AND: w_alu = w_a & w_b;
                    C_FN_OR:  w_alu = w_a | w_b;
                    C_FN_MUL, C_FN_DIV: w_alu = 16'h0000;
                    default:  w_bad_fn = 1'b1;
                endcase
            end
            C_OP_ANDI:         w_alu = w_a & ex.SE_offset_EX;
            C_OP_ORI:          w_alu = w_a | ex.SE_offset_EX;
            C_OP_LW, C_OP_SW:  w_alu = w_b_reg + ex.SE_offset_EX;
            default:           w_alu = w_a + w_b;
        endcase
    end

    ex_muldiv u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start),
        .is_div (ex.FN_offset_EX == C_FN_DIV),
        .a      (w_a),
        .b      (w_b),
        .stall  (w_stall),
        .done   (w_md_done),
        .res_lo (w_md_lo),
        .res_hi (w_md_hi)
    );

    // While the mul/div unit holds the stage, EX/MEM sees bubbles until DONE.
    assign w_bubble = ex.flush || w_bad_fn || w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu   <= 16'h0000;
            r_r0    <= 16'h0000;
            r_store <= 16'h0000;
            r_dest  <= 4'h0;
            r_ctrl  <= '0;
            r_ovf   <= 1'b0;
        end else if (w_md_done) begin
            r_alu   <= w_md_lo;
            r_r0    <= w_md_hi;
            r_store <= 16'h0000;
            r_dest  <= ex.RA1_EX;
            r_ctrl  <= w_ctrl;
            r_ovf   <= 1'b0;
        end else if (w_bubble) begin
            r_alu   <= 16'h0000;
            r_r0    <= 16'h0000;
            r_store <= 16'h0000;
            r_dest  <= 4'h0;
            r_ctrl  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_alu   <= w_alu;
            r_r0    <= 16'h0000;
            r_store <= w_a;
            r_dest  <= ex.RA1_EX;
            r_ctrl  <= w_ctrl;
            r_ovf   <= w_ovf;
        end
    end

    assign ex.alu_result_MEM = r_alu;
    assign ex.r0_result_MEM  = r_r0;
    assign ex.store_data_MEM = r_store;
    assign ex.dest_MEM       = r_dest;
    assign ex.regWrite_MEM   = r_ctrl.reg_write;
    assign ex.r0Write_MEM    = r_ctrl.r0_write;
    assign ex.memRead_MEM    = r_ctrl.mem_read;
    assign ex.memWrite_MEM   = r_ctrl.mem_write;
    assign ex.memSource_MEM  = r_ctrl.mem_source;
    assign ex.ovf_MEM        = r_ovf;
    assign ex.stall_EX       = w_stall;
endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Directed self-checking bench for execute_stage.
// Revision : 1.0
// ============================================================================
module tb_execute_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    execute_stage_if bus();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: regWrite, r0Write, memRead, memWrite, memSource, ovf
    function automatic logic [5:0] ctrl_out();
        return {bus.regWrite_MEM, bus.r0Write_MEM, bus.memRead_MEM,
                bus.memWrite_MEM, bus.memSource_MEM, bus.ovf_MEM};
    endfunction

    task automatic clear_inputs();
        bus.flush = 0; bus.opcode_EX = 0; bus.FN_offset_EX = 0;
        bus.RA1_EX = 0; bus.RA2_EX = 0; bus.RD1_EX = 0; bus.RD2_EX = 0;
        bus.SE_offset_EX = 0; bus.regWrite_EX = 0; bus.r0Write_EX = 0;
        bus.alusource_EX = 0; bus.memRead_EX = 0; bus.memWrite_EX = 0;
        bus.memSource_EX = 0; bus.fwd_mem_we = 0; bus.fwd_wb_we = 0;
        bus.fwd_mem_reg = 0; bus.fwd_wb_reg = 0; bus.fwd_mem_data = 0;
        bus.fwd_wb_data = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [3:0] fn,
                          input logic [3:0] ra1, input logic [3:0] ra2,
                          input logic [15:0] rd1, input logic [15:0] rd2);
        clear_inputs();
        bus.opcode_EX = op; bus.FN_offset_EX = fn;
        bus.RA1_EX = ra1; bus.RA2_EX = ra2;
        bus.RD1_EX = rd1; bus.RD2_EX = rd2;
        bus.regWrite_EX = 1'b1;
    endtask

    // Counts stalled cycles from the current one, then waits through the DONE edge.
    task automatic run_md(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.stall_EX) begin
                n++;
                @(negedge clk);
            end else begin
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.alu_result_MEM, bus.r0_result_MEM, bus.store_data_MEM,
             bus.dest_MEM, ctrl_out(), bus.stall_EX} !== 59'h0) begin
            errors++;
            $display("FAIL reset_state: got alu=%h r0=%h st=%h dest=%h ctrl=%b stall=%b expected all 0",
                     bus.alu_result_MEM, bus.r0_result_MEM, bus.store_data_MEM,
                     bus.dest_MEM, ctrl_out(), bus.stall_EX);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [15:0] exp_res [6];
        logic        exp_ovf [6];
        logic [3:0]  fns     [6];
        logic [15:0] as      [6];
        logic [15:0] bs      [6];
        fns = '{4'h0, 4'h1, 4'h1, 4'h4, 4'h5, 4'h0};
        as  = '{16'h7FFF, 16'h8000, 16'h0005, 16'hF0F0, 16'hF0F0, 16'h8000};
        bs  = '{16'h0001, 16'h0001, 16'h0003, 16'hFF00, 16'hFF00, 16'h8000};
        exp_res = '{16'h8000, 16'h7FFF, 16'h0002, 16'hF000, 16'hFFF0, 16'h0000};
        exp_ovf = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(4'hF, fns[i], 4'd1, 4'd2, as[i], bs[i]);
            @(posedge clk); #1;
            checks++;
            if ({bus.alu_result_MEM, bus.ovf_MEM, bus.regWrite_MEM, bus.dest_MEM} !==
                {exp_res[i], exp_ovf[i], 1'b1, 4'd1}) begin
                errors++;
                $display("FAIL alu_vec%0d: got res=%h ovf=%b rw=%b dest=%h expected res=%h ovf=%b rw=1 dest=1",
                         i, bus.alu_result_MEM, bus.ovf_MEM, bus.regWrite_MEM,
                         bus.dest_MEM, exp_res[i], exp_ovf[i]);
            end
        end
        @(negedge clk);
        set_op(4'hF, 4'h0, 4'd1, 4'd2, 16'h0010, 16'h5555);
        bus.alusource_EX = 1'b1; bus.SE_offset_EX = 16'hFFFF;
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, bus.ovf_MEM} !== {16'h000F, 1'b0}) begin
            errors++;
            $display("FAIL add_imm: got res=%h ovf=%b expected res=000f ovf=0",
                     bus.alu_result_MEM, bus.ovf_MEM);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        set_op(4'hF, 4'h0, 4'd4, 4'd3, 16'h0005, 16'h0099);
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 4'd3; bus.fwd_mem_data = 16'h0010;
        bus.fwd_wb_we = 1;  bus.fwd_wb_reg = 4'd3;  bus.fwd_wb_data = 16'h0020;
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_MEM !== 16'h0015) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %h expected 0015", bus.alu_result_MEM);
        end
        @(negedge clk);
        bus.fwd_mem_we = 0;
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_MEM !== 16'h0025) begin
            errors++;
            $display("FAIL fwd_wb: got %h expected 0025", bus.alu_result_MEM);
        end
        @(negedge clk);
        set_op(4'hF, 4'h0, 4'd0, 4'd2, 16'h7777, 16'h0001);
        bus.fwd_wb_we = 1; bus.fwd_wb_reg = 4'd0; bus.fwd_wb_data = 16'h0100;
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_MEM !== 16'h0101) begin
            errors++;
            $display("FAIL fwd_r0: got %h expected 0101", bus.alu_result_MEM);
        end
    endtask

    task automatic test_imm_and_other();
        @(negedge clk);
        set_op(4'h1, 4'h0, 4'd1, 4'd2, 16'h1234, 16'hAAAA);
        bus.SE_offset_EX = 16'h00FF;
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_MEM !== 16'h0034) begin
            errors++;
            $display("FAIL andi: got %h expected 0034", bus.alu_result_MEM);
        end
        @(negedge clk);
        bus.opcode_EX = 4'h2;
        @(posedge clk); #1;
        checks++;
        if (bus.alu_result_MEM !== 16'h12FF) begin
            errors++;
            $display("FAIL ori: got %h expected 12ff", bus.alu_result_MEM);
        end
        @(negedge clk);
        set_op(4'h3, 4'h0, 4'd1, 4'd2, 16'h0002, 16'h0003);
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, bus.ovf_MEM} !== {16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL passthrough: got res=%h ovf=%b expected 0005 ovf=0",
                     bus.alu_result_MEM, bus.ovf_MEM);
        end
        @(negedge clk);
        set_op(4'hF, 4'h2, 4'd1, 4'd2, 16'h0002, 16'h0003);
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, ctrl_out()} !== 22'h0) begin
            errors++;
            $display("FAIL bad_fn_bubble: got res=%h ctrl=%b expected 0",
                     bus.alu_result_MEM, ctrl_out());
        end
    endtask

    task automatic test_load_store();
        @(negedge clk);
        set_op(4'h8, 4'h4, 4'd7, 4'd2, 16'h1111, 16'hFFFE);
        bus.SE_offset_EX = 16'h0004; bus.memRead_EX = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, ctrl_out(), bus.dest_MEM} !== {16'h0002, 6'b101000, 4'd7}) begin
            errors++;
            $display("FAIL lw_addr: got addr=%h ctrl=%b dest=%h expected 0002 101000 7",
                     bus.alu_result_MEM, ctrl_out(), bus.dest_MEM);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ctrl_out() !== 6'b000000) begin
            errors++;
            $display("FAIL lw_flush: got ctrl=%b expected 000000", ctrl_out());
        end
        @(negedge clk);
        set_op(4'hB, 4'h0, 4'd6, 4'd2, 16'hABCD, 16'h0100);
        bus.regWrite_EX = 0; bus.memWrite_EX = 1; bus.SE_offset_EX = 16'h0010;
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 4'd6; bus.fwd_mem_data = 16'h1357;
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, bus.store_data_MEM, ctrl_out()} !==
            {16'h0110, 16'h1357, 6'b000100}) begin
            errors++;
            $display("FAIL sw: got addr=%h data=%h ctrl=%b expected 0110 1357 000100",
                     bus.alu_result_MEM, bus.store_data_MEM, ctrl_out());
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  fns  [5];
        logic [15:0] as   [5];
        logic [15:0] bs   [5];
        logic [15:0] e_lo [5];
        logic [15:0] e_hi [5];
        int          e_n  [5];
        int          n;
        fns  = '{4'h8, 4'h8, 4'h9, 4'h9, 4'h9};
        as   = '{16'hFFFD, 16'h8000, 16'hFFF9, 16'h8000, 16'h0009};
        bs   = '{16'h4000, 16'h8000, 16'h0002, 16'hFFFF, 16'h0000};
        e_lo = '{16'h4000, 16'h0000, 16'hFFFD, 16'h8000, 16'hFFFF};
        e_hi = '{16'hFFFF, 16'h4000, 16'hFFFF, 16'h0000, 16'h0009};
        e_n  = '{17, 17, 17, 17, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_op(4'hF, fns[i], 4'd9, 4'd2, as[i], bs[i]);
            bus.r0Write_EX = 1'b1;
            // A stale WB tap on RA2 is cleared mid-flight; it must not matter.
            bus.fwd_wb_we = 1'b1; bus.fwd_wb_reg = 4'd2; bus.fwd_wb_data = bs[i];
            bus.RD2_EX = 16'h0101;
            @(negedge clk);
            bus.fwd_wb_we = 1'b0;
            #1;
            checks++;
            if (ctrl_out() !== 6'b000000) begin
                errors++;
                $display("FAIL md%0d_bubble: got ctrl=%b expected 000000", i, ctrl_out());
            end
            run_md(n);
            n = n + 1;
            checks++;
            if (n !== e_n[i]) begin
                errors++;
                $display("FAIL md%0d_stall_len: got %0d cycles expected %0d", i, n, e_n[i]);
            end
            checks++;
            if ({bus.alu_result_MEM, bus.r0_result_MEM, ctrl_out(), bus.dest_MEM} !==
                {e_lo[i], e_hi[i], 6'b110000, 4'd9}) begin
                errors++;
                $display("FAIL md%0d_result: got lo=%h hi=%h ctrl=%b dest=%h expected lo=%h hi=%h ctrl=110000 dest=9",
                         i, bus.alu_result_MEM, bus.r0_result_MEM, ctrl_out(),
                         bus.dest_MEM, e_lo[i], e_hi[i]);
            end
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        set_op(4'hF, 4'h8, 4'd1, 4'd2, 16'h0003, 16'h0003);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, bus.r0_result_MEM, bus.store_data_MEM,
             bus.dest_MEM, ctrl_out(), bus.stall_EX} !== 59'h0) begin
            errors++;
            $display("FAIL reset_busy: got alu=%h r0=%h ctrl=%b stall=%b expected all 0",
                     bus.alu_result_MEM, bus.r0_result_MEM, ctrl_out(), bus.stall_EX);
        end
        @(negedge clk);
        reset = 1'b0;
        set_op(4'hF, 4'h0, 4'd5, 4'd2, 16'h0002, 16'h0003);
        #1;
        checks++;
        if (bus.stall_EX !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_stall: got %b expected 0", bus.stall_EX);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_result_MEM, bus.r0_result_MEM, bus.regWrite_MEM, bus.dest_MEM} !==
            {16'h0005, 16'h0000, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL post_reset_add: got res=%h r0=%h rw=%b dest=%h expected 0005 0000 1 5",
                     bus.alu_result_MEM, bus.r0_result_MEM, bus.regWrite_MEM, bus.dest_MEM);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_alu();
        test_forwarding();
        test_imm_and_other();
        test_load_store();
        test_muldiv();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
